// File: rtl/riscv_pkg.sv
// Shared types for the core's memory-side blocks: access sizes, arbiter
// states, port ownership, and the alignment rule used for error checks.
package riscv_pkg;

    // Access size encoding as presented on the load/store port; 2'd3 is illegal.
    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ArbIdle  = 2'd0,
        ArbIssue = 2'd1,
        ArbWait  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnFetch = 1'b0,
        OwnData  = 1'b1
    } arb_owner_e;

    // True when the access cannot be performed as a single aligned lane access.
    // The illegal size code is reported here too so callers need one flag only.
    function automatic logic size_misaligned(input logic [1:0] size,
                                             input logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        case (size)
            MemByte: bad = 1'b0;
            MemHalf: bad = offset[0];
            MemWord: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit SRAM word and sub-word accesses:
// store strobes and lane replication, load lane select and extension.
module mem_lane_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] st_data_in,
    output logic [3:0]      st_be,
    output logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_raw,
    output logic [XLEN-1:0] ld_data,
    output logic            misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Each lane carries the right-aligned store chunk that maps onto it, so
    // whichever lanes are strobed see the correct bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign st_data[gi*8 +: 8] =
                (size == MemByte) ? st_data_in[7:0] :
                (size == MemHalf) ? st_data_in[(gi % 2)*8 +: 8] :
                                    st_data_in[gi*8 +: 8];
        end
    endgenerate

    // Byte enables shift with the address offset; illegal size strobes nothing.
    always_comb begin
        st_be = 4'b0000;
        case (size)
            MemByte: st_be = 4'b0001 << offset;
            MemHalf: st_be = 4'b0011 << offset;
            MemWord: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    assign ld_byte    = ld_raw[{offset, 3'b000} +: 8];
    assign ld_half    = ld_raw[{offset[1], 4'b0000} +: 16];
    assign misaligned = size_misaligned(size, offset);

    // Pick the addressed lane and extend it to the full register width.
    always_comb begin
        ld_data = ld_raw;
        case (size)
            MemByte: ld_data = is_unsigned ? {{(XLEN-8){1'b0}}, ld_byte}
                                           : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            MemHalf: ld_data = is_unsigned ? {{(XLEN-16){1'b0}}, ld_half}
                                           : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store.
// One transaction at a time: accept (IDLE), drive SRAM (ISSUE), respond (WAIT).
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int MEM_WORDS  = 1024,
    parameter  int MAX_STREAK = 4,
    localparam int AW         = $clog2(MEM_WORDS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_valid_i,
    output logic            if_req_ready_o,
    input  logic [XLEN-1:0] if_req_addr_i,
    output logic            if_rsp_valid_o,
    output logic [XLEN-1:0] if_rsp_data_o,
    output logic            if_rsp_err_o,
    input  logic            d_req_valid_i,
    output logic            d_req_ready_o,
    input  logic            d_req_we_i,
    input  logic [1:0]      d_req_size_i,
    input  logic            d_req_unsigned_i,
    input  logic [XLEN-1:0] d_req_addr_i,
    input  logic [XLEN-1:0] d_req_wdata_i,
    output logic            d_rsp_valid_o,
    output logic [XLEN-1:0] d_rsp_rdata_o,
    output logic            d_rsp_err_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam int              SW        = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(4 * MEM_WORDS);

    arb_state_e      state_reg, state_next;
    logic [SW-1:0]   streak_reg, streak_next;
    arb_owner_e      owner_reg;
    logic            we_reg;
    logic [1:0]      size_reg;
    logic            unsigned_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;

    logic            accept_open;
    logic            streak_full;
    logic            fetch_wins;
    logic            handshake;
    logic            err;
    logic            misaligned;
    logic            issue_access;
    logic            issue_store;
    logic            in_wait;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;

    // Arbitration: data normally wins, but a waiting fetch is forced through
    // once data has been granted MAX_STREAK times in a row past it.
    assign accept_open    = (state_reg == ArbIdle) && !rst_i;
    assign streak_full    = (streak_reg == STREAK_MAX);
    assign fetch_wins     = if_req_valid_i && (!d_req_valid_i || streak_full);
    assign if_req_ready_o = accept_open && fetch_wins;
    assign d_req_ready_o  = accept_open && d_req_valid_i && !fetch_wins;
    assign handshake      = if_req_ready_o || d_req_ready_o;

    // State and starvation counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ArbIdle;
            streak_reg <= '0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
        end
    end

    // Fixed three-step sequence per transaction; no early exits.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ArbIdle:  if (handshake) state_next = ArbIssue;
            ArbIssue: state_next = ArbWait;
            ArbWait:  state_next = ArbIdle;
            default:  state_next = ArbIdle;
        endcase
    end

    // Streak counts data grants that bypassed a pending fetch.
    always_comb begin
        streak_next = streak_reg;
        if (if_req_ready_o) begin
            streak_next = '0;
        end else if (d_req_ready_o && if_req_valid_i && !streak_full) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    // Capture the winning request; later input changes are ignored.
    // A fetch is recorded as an unsigned word load so the shared checks apply.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_reg    <= OwnFetch;
            we_reg       <= 1'b0;
            size_reg     <= 2'd0;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else if (if_req_ready_o) begin
            owner_reg    <= OwnFetch;
            we_reg       <= 1'b0;
            size_reg     <= MemWord;
            unsigned_reg <= 1'b1;
            addr_reg     <= if_req_addr_i;
            wdata_reg    <= '0;
        end else if (d_req_ready_o) begin
            owner_reg    <= OwnData;
            we_reg       <= d_req_we_i;
            size_reg     <= d_req_size_i;
            unsigned_reg <= d_req_unsigned_i;
            addr_reg     <= d_req_addr_i;
            wdata_reg    <= d_req_wdata_i;
        end
    end

    mem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .size        (size_reg),
        .offset      (addr_reg[1:0]),
        .is_unsigned (unsigned_reg),
        .st_data_in  (wdata_reg),
        .st_be       (st_be),
        .st_data     (st_data),
        .ld_raw      (mem_rdata_i),
        .ld_data     (ld_data),
        .misaligned  (misaligned)
    );

    assign err          = misaligned || (addr_reg >= MEM_BYTES);
    assign issue_access = (state_reg == ArbIssue) && !err;
    assign issue_store  = issue_access && we_reg;
    assign in_wait      = (state_reg == ArbWait);

    // SRAM strobe: only during ISSUE, suppressed entirely for bad accesses.
    always_comb begin
        mem_en_o    = issue_access;
        mem_we_o    = issue_store;
        mem_be_o    = issue_store ? st_be : 4'b0000;
        mem_addr_o  = issue_access ? addr_reg[AW+1:2] : '0;
        mem_wdata_o = issue_store ? st_data : '0;
    end

    // Responses pulse in WAIT for the owner only; errors return zero data.
    always_comb begin
        if_rsp_valid_o = in_wait && (owner_reg == OwnFetch);
        if_rsp_err_o   = if_rsp_valid_o && err;
        if_rsp_data_o  = (if_rsp_valid_o && !err) ? mem_rdata_i : '0;
        d_rsp_valid_o  = in_wait && (owner_reg == OwnData);
        d_rsp_err_o    = d_rsp_valid_o && err;
        d_rsp_rdata_o  = (d_rsp_valid_o && !err && !we_reg) ? ld_data : '0;
    end

endmodule
